// File: rtl/esfa_sequencer_if.sv
// Command/response port of the ESFA sequencer: valid/ready command in, valid/ready response out.
interface esfa_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_handle;
    logic [7:0] cmd_index;
    logic [7:0] cmd_value;
    logic [7:0] cmd_sel;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_value;
    logic       rsp_hit;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, cmd_sel, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_value, rsp_hit, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_handle, cmd_index, cmd_value, cmd_sel, rsp_ready,
        output cmd_ready, rsp_valid, rsp_value, rsp_hit, rsp_err
    );
endinterface

// File: rtl/esfa_sequencer.sv
// Expands one high-level command into a spaced micro-sequence of ESFA selector opcodes
// and reports the final (or aborting) step result; also owns the ESFA init reset pulse.
module esfa_sequencer #(
    parameter int unsigned SETTLE      = 1,
    parameter int unsigned INIT_CYCLES = 4,
    parameter int unsigned IDLE_SEL    = 8
) (
    input  logic              clk,
    input  logic              reset,
    esfa_sequencer_if.slave   host,
    output logic              busy,
    output logic              esfa_reset,
    output logic [7:0]        esfa_selector,
    output logic [7:0]        esfa_queried_handle,
    output logic [7:0]        esfa_new_index,
    output logic [7:0]        esfa_new_value,
    input  logic              esfa_result_bool,
    input  logic [7:0]        esfa_result_value
);
    localparam logic [7:0] IDLE_SEL8   = 8'(IDLE_SEL);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [7:0] INIT_LAST   = 8'(INIT_CYCLES - 1);
    localparam logic [1:0] OP_ALLOC    = 2'd1;
    localparam logic [1:0] OP_UPDATE   = 2'd2;
    localparam logic [1:0] OP_RAW      = 2'd3;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_SETTLE, S_RESP} state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [1:0] step;
    logic [1:0] op;
    logic [7:0] raw_sel;

    function automatic logic [7:0] prog_sel(input logic [1:0] o, input logic [1:0] s,
                                            input logic [7:0] raw);
        logic [7:0] r;
        r = 8'd2;
        case (o)
            2'd0: r = 8'd2;
            2'd1: r = 8'd5;
            2'd2: case (s)
                      2'd0:    r = 8'd2;
                      2'd1:    r = 8'd5;
                      2'd2:    r = 8'd6;
                      default: r = 8'd4;
                  endcase
            default: r = raw;
        endcase
        return r;
    endfunction

    function automatic logic must_hit(input logic [1:0] o, input logic [1:0] s);
        return (o == OP_ALLOC) || (o == OP_UPDATE && s <= 2'd1);
    endfunction

    function automatic logic [1:0] last_step(input logic [1:0] o);
        return (o == OP_UPDATE) ? 2'd3 : 2'd0;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= S_INIT;
            cnt                 <= '0;
            step                <= '0;
            op                  <= '0;
            raw_sel             <= '0;
            busy                <= 1'b1;
            esfa_reset          <= 1'b0;
            esfa_selector       <= IDLE_SEL8;
            esfa_queried_handle <= '0;
            esfa_new_index      <= '0;
            esfa_new_value      <= '0;
            host.cmd_ready      <= 1'b0;
            host.rsp_valid      <= 1'b0;
            host.rsp_value      <= '0;
            host.rsp_hit        <= 1'b0;
            host.rsp_err        <= 1'b0;
        end else begin
            case (state)
                // esfa_reset releases one cycle before IDLE so the array sees a clean edge first
                S_INIT: begin
                    if (!esfa_reset) begin
                        if (cnt == INIT_LAST) esfa_reset <= 1'b1;
                        else                  cnt        <= cnt + 8'd1;
                    end else begin
                        state          <= S_IDLE;
                        host.cmd_ready <= 1'b1;
                        busy           <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (host.cmd_valid) begin
                        host.cmd_ready      <= 1'b0;
                        busy                <= 1'b1;
                        op                  <= host.cmd_op;
                        raw_sel             <= host.cmd_sel;
                        esfa_queried_handle <= host.cmd_handle;
                        esfa_new_index      <= host.cmd_index;
                        esfa_new_value      <= host.cmd_value;
                        step                <= '0;
                        if (host.cmd_op == OP_RAW && host.cmd_sel >= IDLE_SEL8) begin
                            state          <= S_RESP;
                            host.rsp_valid <= 1'b1;
                            host.rsp_err   <= 1'b1;
                            host.rsp_value <= 8'hFF;
                            host.rsp_hit   <= 1'b0;
                        end else begin
                            state         <= S_ISSUE;
                            esfa_selector <= prog_sel(host.cmd_op, 2'd0, host.cmd_sel);
                        end
                    end
                end
                S_ISSUE: begin
                    esfa_selector <= IDLE_SEL8;
                    cnt           <= '0;
                    state         <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (cnt != SETTLE_LAST) begin
                        cnt <= cnt + 8'd1;
                    end else if (must_hit(op, step) && !esfa_result_bool) begin
                        state          <= S_RESP;
                        host.rsp_valid <= 1'b1;
                        host.rsp_err   <= 1'b1;
                        host.rsp_value <= {6'd0, step};
                        host.rsp_hit   <= 1'b0;
                    end else if (step == last_step(op)) begin
                        state          <= S_RESP;
                        host.rsp_valid <= 1'b1;
                        host.rsp_err   <= 1'b0;
                        host.rsp_value <= esfa_result_value;
                        host.rsp_hit   <= esfa_result_bool;
                    end else begin
                        step          <= step + 2'd1;
                        state         <= S_ISSUE;
                        esfa_selector <= prog_sel(op, step + 2'd1, raw_sel);
                    end
                end
                S_RESP: begin
                    if (host.rsp_ready) begin
                        host.rsp_valid <= 1'b0;
                        host.cmd_ready <= 1'b1;
                        busy           <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_esfa_sequencer.sv
// Directed bench for esfa_sequencer with a small ESFA result model keyed on the last issued selector.
module tb_esfa_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       busy, esfa_reset;
    logic [7:0] esfa_selector, esfa_queried_handle, esfa_new_index, esfa_new_value;
    logic       esfa_result_bool;
    logic [7:0] esfa_result_value;

    esfa_sequencer_if bus();

    esfa_sequencer #(.SETTLE(1), .INIT_CYCLES(4), .IDLE_SEL(8)) dut (
        .clk                 (clk),
        .reset               (reset),
        .host                (bus),
        .busy                (busy),
        .esfa_reset          (esfa_reset),
        .esfa_selector       (esfa_selector),
        .esfa_queried_handle (esfa_queried_handle),
        .esfa_new_index      (esfa_new_index),
        .esfa_new_value      (esfa_new_value),
        .esfa_result_bool    (esfa_result_bool),
        .esfa_result_value   (esfa_result_value)
    );

    always #5 clk = ~clk;

    // ESFA model: result reflects the most recent non-idle selector; fail_sel answers bool 0
    logic [7:0] last_sel = 8'd8;
    logic [7:0] fail_sel = 8'hFF;
    logic [7:0] res_val  = 8'h00;
    always @(posedge clk) if (esfa_selector != 8'd8) last_sel <= esfa_selector;
    assign esfa_result_bool  = (last_sel != fail_sel);
    assign esfa_result_value = res_val;

    int         passed = 0;
    int         total  = 0;
    int         lat;
    bit         ops_ok;
    logic [7:0] trace[$];

    function automatic bit trace_is(input logic [63:0] e, input int len);
        if (trace.size() != len) return 1'b0;
        for (int k = 0; k < len; k++)
            if (trace[k] !== e[8*(len-1-k) +: 8]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_cmd(input logic [1:0] op, input logic [7:0] h, input logic [7:0] i,
                           input logic [7:0] v, input logic [7:0] s);
        trace.delete();
        lat    = 0;
        ops_ok = 1'b1;
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_handle = h; bus.cmd_index = i; bus.cmd_value = v;
        bus.cmd_sel = s; bus.cmd_valid = 1'b1;
        for (int n = 0; n < 20 && bus.cmd_ready !== 1'b1; n++) @(negedge clk);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                lat = n;
                break;
            end
            trace.push_back(esfa_selector);
            if ({esfa_queried_handle, esfa_new_index, esfa_new_value} !== {h, i, v}) ops_ok = 1'b0;
        end
    endtask

    task automatic release_and_init(input string tag);
        int  edges;
        bit  sel_ok;
        bit  no_rsp;
        edges  = 0;
        sel_ok = 1'b1;
        no_rsp = 1'b1;
        @(negedge clk) reset = 1'b1;
        while (esfa_reset !== 1'b1 && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
            if (esfa_selector !== 8'd8) sel_ok = 1'b0;
            if (bus.rsp_valid !== 1'b0) no_rsp = 1'b0;
        end
        total++;
        if (edges !== 4) $display("FAIL %s_init_len: got %0d edges, want 4", tag, edges);
        else passed++;
        total++;
        if (bus.cmd_ready !== 1'b0) $display("FAIL %s_ready_early: got %b want 0", tag, bus.cmd_ready);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({bus.cmd_ready, busy} !== 2'b10) $display("FAIL %s_ready: got ready/busy %b want 10", tag, {bus.cmd_ready, busy});
        else passed++;
        total++;
        if (!(sel_ok && no_rsp && esfa_selector === 8'd8)) $display("FAIL %s_init_sel: got sel_ok %b no_rsp %b want 1 1", tag, sel_ok, no_rsp);
        else passed++;
    endtask

    task automatic test_reset;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_handle = '0; bus.cmd_index = '0;
        bus.cmd_value = '0; bus.cmd_sel = '0; bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({esfa_reset, esfa_selector, bus.cmd_ready, busy} !== {1'b0, 8'd8, 1'b0, 1'b1})
            $display("FAIL reset_ctl: got esfa_reset %b sel %0d ready %b busy %b want 0 8 0 1",
                     esfa_reset, esfa_selector, bus.cmd_ready, busy);
        else passed++;
        total++;
        if ({esfa_queried_handle, esfa_new_index, esfa_new_value, bus.rsp_valid, bus.rsp_value,
             bus.rsp_hit, bus.rsp_err} !== '0)
            $display("FAIL reset_data: got h %h i %h v %h rv %b val %h hit %b err %b want all 0",
                     esfa_queried_handle, esfa_new_index, esfa_new_value, bus.rsp_valid,
                     bus.rsp_value, bus.rsp_hit, bus.rsp_err);
        else passed++;
        release_and_init("por");
    endtask

    task automatic consume;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.cmd_ready} !== 2'b01)
            $display("FAIL rsp_consume: got valid/ready %b want 01", {bus.rsp_valid, bus.cmd_ready});
        else passed++;
    endtask

    task automatic test_lookup_hit;
        fail_sel = 8'hFF; res_val = 8'h5A;
        run_cmd(2'd0, 8'd3, 8'd0, 8'd0, 8'd0);
        total++;
        if (lat !== 3) $display("FAIL lookup_lat: got %0d want 3", lat); else passed++;
        total++;
        if (!trace_is(64'h0208, 2)) $display("FAIL lookup_seq: got %p want 2 8", trace); else passed++;
        total++;
        if ({bus.rsp_value, bus.rsp_hit, bus.rsp_err} !== {8'h5A, 1'b1, 1'b0})
            $display("FAIL lookup_rsp: got %h %b %b want 5a 1 0", bus.rsp_value, bus.rsp_hit, bus.rsp_err);
        else passed++;
        total++;
        if (!ops_ok || esfa_queried_handle !== 8'd3) $display("FAIL lookup_ops: got handle %h want 03", esfa_queried_handle);
        else passed++;
        consume();
    endtask

    task automatic test_lookup_miss;
        fail_sel = 8'd2; res_val = 8'h33;
        run_cmd(2'd0, 8'd4, 8'd0, 8'd0, 8'd0);
        total++;
        if ({lat, bus.rsp_value, bus.rsp_hit, bus.rsp_err} !== {32'd3, 8'h33, 1'b0, 1'b0})
            $display("FAIL lookup_miss: got lat %0d %h %b %b want 3 33 0 0", lat, bus.rsp_value, bus.rsp_hit, bus.rsp_err);
        else passed++;
        consume();
    endtask

    task automatic test_update_abort;
        fail_sel = 8'd5; res_val = 8'h44;
        run_cmd(2'd2, 8'h10, 8'h20, 8'h30, 8'd0);
        total++;
        if (!trace_is(64'h02080508, 4)) $display("FAIL abort_seq: got %p want 2 8 5 8", trace); else passed++;
        total++;
        if ({lat, bus.rsp_value, bus.rsp_hit, bus.rsp_err} !== {32'd5, 8'h01, 1'b0, 1'b1})
            $display("FAIL abort_rsp: got lat %0d %h %b %b want 5 01 0 1", lat, bus.rsp_value, bus.rsp_hit, bus.rsp_err);
        else passed++;
        consume();
    endtask

    task automatic test_update_success;
        fail_sel = 8'hFF; res_val = 8'h07;
        run_cmd(2'd2, 8'h11, 8'h22, 8'h33, 8'd0);
        total++;
        if (!trace_is(64'h0208050806080408, 8)) $display("FAIL update_seq: got %p want 2 8 5 8 6 8 4 8", trace);
        else passed++;
        total++;
        if ({lat, bus.rsp_value, bus.rsp_hit, bus.rsp_err} !== {32'd9, 8'h07, 1'b1, 1'b0})
            $display("FAIL update_rsp: got lat %0d %h %b %b want 9 07 1 0", lat, bus.rsp_value, bus.rsp_hit, bus.rsp_err);
        else passed++;
        total++;
        if (!ops_ok || {esfa_queried_handle, esfa_new_index, esfa_new_value} !== 24'h112233)
            $display("FAIL update_ops: got %h%h%h want 112233", esfa_queried_handle, esfa_new_index, esfa_new_value);
        else passed++;
        consume();
    endtask

    task automatic test_alloc_abort;
        fail_sel = 8'd5; res_val = 8'h00;
        run_cmd(2'd1, 8'h01, 8'h02, 8'h03, 8'd0);
        total++;
        if (!trace_is(64'h0508, 2) || {lat, bus.rsp_value, bus.rsp_err} !== {32'd3, 8'h00, 1'b1})
            $display("FAIL alloc_abort: got lat %0d val %h err %b seq %p want 3 00 1 (5 8)", lat, bus.rsp_value, bus.rsp_err, trace);
        else passed++;
        consume();
    endtask

    task automatic test_raw_ok;
        fail_sel = 8'hFF; res_val = 8'h9C;
        run_cmd(2'd3, 8'h00, 8'h00, 8'h00, 8'd7);
        total++;
        if (!trace_is(64'h0708, 2) || {lat, bus.rsp_value, bus.rsp_err} !== {32'd3, 8'h9C, 1'b0})
            $display("FAIL raw_ok: got lat %0d val %h err %b seq %p want 3 9c 0 (7 8)", lat, bus.rsp_value, bus.rsp_err, trace);
        else passed++;
        consume();
    endtask

    task automatic test_raw_reject;
        logic [7:0] sels [2];
        sels[0] = 8'd9;
        sels[1] = 8'd8;
        foreach (sels[k]) begin
            bus.rsp_ready = 1'b0;
            run_cmd(2'd3, 8'hAA, 8'hBB, 8'hCC, sels[k]);
            total++;
            if (trace.size() != 0 || {lat, bus.rsp_value, bus.rsp_hit, bus.rsp_err} !== {32'd1, 8'hFF, 1'b0, 1'b1})
                $display("FAIL raw_reject_%0d: got lat %0d %h %b %b issued %0d want 1 ff 0 1 0",
                         sels[k], lat, bus.rsp_value, bus.rsp_hit, bus.rsp_err, trace.size());
            else passed++;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                total++;
                if ({bus.rsp_valid, bus.rsp_value, bus.rsp_err, bus.cmd_ready, esfa_selector} !==
                    {1'b1, 8'hFF, 1'b1, 1'b0, 8'd8})
                    $display("FAIL stall_%0d: got valid %b val %h err %b ready %b sel %0d want 1 ff 1 0 8",
                             c, bus.rsp_valid, bus.rsp_value, bus.rsp_err, bus.cmd_ready, esfa_selector);
                else passed++;
            end
            bus.rsp_ready = 1'b1;
            consume();
        end
    endtask

    task automatic test_reset_mid_update;
        int n;
        fail_sel = 8'hFF; res_val = 8'h07;
        @(negedge clk);
        bus.cmd_op = 2'd2; bus.cmd_handle = 8'h5; bus.cmd_index = 8'h6; bus.cmd_value = 8'h7;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        while (esfa_selector !== 8'd6 && n < 30) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (esfa_selector !== 8'd6) $display("FAIL mid_reach_step2: got sel %0d want 6", esfa_selector);
        else passed++;
        #1 reset = 1'b0;
        #1;
        total++;
        if ({esfa_reset, esfa_selector, bus.cmd_ready, busy, bus.rsp_valid,
             esfa_queried_handle, esfa_new_index, esfa_new_value} !== {1'b0, 8'd8, 1'b0, 1'b1, 1'b0, 24'h0})
            $display("FAIL mid_reset_async: got rst %b sel %0d ready %b busy %b rv %b ops %h%h%h want 0 8 0 1 0 000000",
                     esfa_reset, esfa_selector, bus.cmd_ready, busy, bus.rsp_valid,
                     esfa_queried_handle, esfa_new_index, esfa_new_value);
        else passed++;
        repeat (2) @(posedge clk);
        release_and_init("mid");
    endtask

    initial begin
        test_reset();
        test_lookup_hit();
        test_lookup_miss();
        test_update_abort();
        test_update_success();
        test_alloc_abort();
        test_raw_ok();
        test_raw_reject();
        test_reset_mid_update();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/esfa_sequencer.md
# esfa_sequencer

Command sequencer sitting in front of the 8-cell ESFA array. It accepts one high-level command at a time over a valid/ready port and expands it into a fixed micro-sequence of ESFA selector opcodes. Each step is spaced by settle cycles, and the reduced result (bool, value) is sampled after each step. A must-hit failure aborts the sequence. The block also owns the ESFA's init reset pulse and returns one response per command over a valid/ready port.

## Interface
- SETTLE, 1: hold cycles (selector = IDLE_SEL) after each issue cycle before sampling result; ≥1
- INIT_CYCLES, 4: cycles esfa_reset is held low after own reset release; 1..255
- IDLE_SEL, 8: ESFA hold/no-op selector
---
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0 LOOKUP, 1 ALLOC, 2 UPDATE, 3 RAW
- cmd_handle / cmd_index / cmd_value  in  8 each  operands
- cmd_sel  in  8  selector for RAW
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_value  out  8  final-step result value, or error code
- rsp_hit  out  1  final-step result bool
- rsp_err  out  1  sequence aborted or command rejected
- busy  out  1  not in IDLE
- esfa_reset  out  1  active-low reset to ESFA, driven synchronously from clk
- esfa_selector  out  8  ESFA opcode
- esfa_queried_handle / esfa_new_index / esfa_new_value  out  8 each  operand registers
- esfa_result_bool  in  1 / esfa_result_value  in  8  ESFA reduction outputs

## Operation
- **States**
  - INIT → IDLE → ISSUE → SETTLE → (ISSUE | RESP) → IDLE.
- **Micro-programs** (`*` = must-hit)
  - LOOKUP = [2]
  - ALLOC = [5*]
  - UPDATE = [2*, 5*, 6, 4]
  - RAW = [cmd_sel]
- **INIT**
  - esfa_reset = 0 and an 8-bit counter counts INIT_CYCLES cycles.
  - Then esfa_reset = 1 and the block enters IDLE.
- **IDLE**
  - cmd_ready = 1 and esfa_selector = IDLE_SEL.
  - On cmd_valid & cmd_ready: latch op and operands into esfa_* operand registers, step = 0, go to ISSUE.
  - Operands hold constant for the whole command and remain at their last value afterwards.
- **RAW rejection**
  - RAW with cmd_sel ≥ IDLE_SEL is rejected: go directly to RESP with rsp_err = 1, rsp_value = 0xFF, rsp_hit = 0, and no selector issued.
- **ISSUE**
  - esfa_selector = program[step] for exactly 1 cycle, then go to SETTLE.
- **SETTLE**
  - esfa_selector = IDLE_SEL for SETTLE cycles.
  - On the clock edge ending the last settle cycle, sample esfa_result_bool/value.
  - If step is must-hit and bool = 0: go to RESP with rsp_err = 1, rsp_value = step index (0..3), rsp_hit = 0.
  - Else, if step is last: go to RESP with rsp_err = 0, rsp_value/rsp_hit = sample.
  - Else: step + 1, go to ISSUE.
- **RESP**
  - rsp_valid = 1; rsp_* are stable until rsp_valid & rsp_ready, then go to IDLE.
  - cmd_ready stays 0 throughout RESP, so back-to-back commands are separated by at least one IDLE cycle.
- **Intermediate results** are not exported; only the final or aborting step is reported.

## Timing
- **Reset values** (async assert)
  - State INIT.
  - esfa_reset 0, esfa_selector IDLE_SEL.
  - esfa operands 0, rsp_valid 0, rsp_value 0, rsp_hit 0, rsp_err 0.
  - cmd_ready 0, busy 1.
- **Reset mid-command**
  - Aborts immediately; no response is produced.
  - ESFA is re-reset through INIT.
- **Latency** (accept at edge t, SETTLE = 1)
  - LOOKUP: ISSUE at cycle t+1, SETTLE at t+2, rsp_valid from t+3.
  - Per step: 1 + SETTLE cycles.
  - UPDATE full path: rsp_valid at t + 1 + 4·(1+SETTLE).
  - Rejected RAW: rsp_valid at t+1.
- **Response stall**: an rsp_ready stall holds RESP indefinitely; rsp_valid may not drop before the handshake.
- **esfa_selector** never carries a non-IDLE_SEL value for 2 consecutive cycles.

## Test plan
- **Init**: release reset → esfa_reset low for exactly 4 cycles, cmd_ready rises the cycle after esfa_reset rises, selector = 8 throughout.
- **LOOKUP hit**: handle 3, ESFA model returns (1, 0x5A) → selector sequence 2, 8; rsp_valid at t+3 with value 0x5A, hit 1, err 0.
- **UPDATE abort**: UPDATE where step 1 (selector 5) returns bool 0 → selectors 2, 8, 5, 8 only; rsp_err 1, rsp_value 1.
- **UPDATE success**: all steps hit, final (1, 0x07) → selectors 2, 8, 5, 8, 6, 8, 4, 8; operands constant throughout; rsp_value 0x07.
- **RAW reject and backpressure**: RAW cmd_sel 9 → rsp_err 1, value 0xFF at t+1, no selector issued; hold rsp_ready low 5 cycles → rsp fields stable, cmd_ready 0.
- **Reset mid-UPDATE**: assert reset during step 2 → outputs take reset values asynchronously, no response; INIT repeats.
